// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and helpers for the 2-D convolution engine
package conv_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 24;
   localparam int K_DEF      = 3;
   localparam int IMG_W_DEF  = 28;
   localparam int IMG_H_DEF  = 28;
   localparam int ADDR_W_DEF = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KERNEL,
      MAC,
      DRAIN,
      OUTPUT,
      DONE
   } state_t;

   // Number of valid kernel positions along one image axis
   function automatic int out_dim(input int size, input int k, input int stride);
      return (size - k) / stride + 1;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - signed multiply-accumulate with clear-on-first-product
module conv_mac
   import conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]           prod_ext;

   // Full-precision signed product, sign-extended to the accumulator width
   always_comb begin
      prod     = $signed(a) * $signed(b);
      prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end

   // Accumulate; the first product of a window overwrites the previous sum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= clr ? prod_ext : acc + prod_ext;
      end
   end

endmodule

// File: rtl/conv2d_stream_engine.sv
// rtl/conv2d_stream_engine.sv - kernel fetch, sliding-window MAC and streamed result output
module conv2d_stream_engine
   import conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int K      = K_DEF,
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_stride,
   input  logic [ADDR_W-1:0] i_src_base,
   input  logic [ADDR_W-1:0] i_krn_base,
   output logic              o_src_rd,
   output logic [ADDR_W-1:0] o_src_addr,
   input  logic [DATA_W-1:0] i_src_data,
   output logic              o_krn_rd,
   output logic [ADDR_W-1:0] o_krn_addr,
   input  logic [DATA_W-1:0] i_krn_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ACC_W-1:0]  o_data,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done
);

   localparam int KK = K * K;
   localparam int CW = $clog2(KK + 1);
   localparam int DW = 16;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [DW-1:0]     kx, ky, ox, oy, ow, oh;
   logic [1:0]        stride;
   logic [1:0]        eff_stride;
   logic [ADDR_W-1:0] src_base, krn_base;
   logic [DATA_W-1:0] kernel [KK];
   logic              krn_rd_q, mac_en, mac_clr;
   logic [CW-1:0]     rd_idx;
   logic [ACC_W-1:0]  acc;
   logic              at_last;

   assign eff_stride = (i_stride == 2'd0) ? 2'd1 : i_stride;
   assign at_last    = (ox == ow - DW'(1)) && (oy == oh - DW'(1));
   assign o_data     = acc;
   assign o_krn_addr = o_krn_rd ? krn_base + ADDR_W'(cnt) : '0;
   assign o_src_addr = o_src_rd
      ? src_base + ADDR_W'((32'(oy) * 32'(stride) + 32'(ky)) * 32'(IMG_W)
                           + 32'(ox) * 32'(stride) + 32'(kx))
      : '0;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and status/strobe decode
   always_comb begin
      state_nxt = state;
      o_krn_rd  = 1'b0;
      o_src_rd  = 1'b0;
      o_valid   = 1'b0;
      o_last    = 1'b0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) state_nxt = LOAD_KERNEL;
         end
         LOAD_KERNEL: begin
            o_busy   = 1'b1;
            o_krn_rd = (cnt < CW'(KK));
            if (cnt == CW'(KK)) state_nxt = MAC;
         end
         MAC: begin
            o_busy   = 1'b1;
            o_src_rd = 1'b1;
            if (cnt == CW'(KK - 1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            o_busy    = 1'b1;
            state_nxt = OUTPUT;
         end
         OUTPUT: begin
            o_busy  = 1'b1;
            o_valid = 1'b1;
            o_last  = at_last;
            if (i_ready) state_nxt = at_last ? DONE : MAC;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters, latched job parameters, kernel store and read-return pipeline
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt      <= '0;
         kx       <= '0;
         ky       <= '0;
         ox       <= '0;
         oy       <= '0;
         ow       <= '0;
         oh       <= '0;
         stride   <= 2'd1;
         src_base <= '0;
         krn_base <= '0;
         krn_rd_q <= 1'b0;
         mac_en   <= 1'b0;
         mac_clr  <= 1'b0;
         rd_idx   <= '0;
         for (int i = 0; i < KK; i++) kernel[i] <= '0;
      end else begin
         krn_rd_q <= o_krn_rd;
         mac_en   <= o_src_rd;
         mac_clr  <= o_src_rd && (cnt == '0);
         rd_idx   <= cnt;
         if (krn_rd_q) kernel[rd_idx] <= i_krn_data;
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  stride   <= eff_stride;
                  src_base <= i_src_base;
                  krn_base <= i_krn_base;
                  ow       <= DW'(out_dim(IMG_W, K, int'(eff_stride)));
                  oh       <= DW'(out_dim(IMG_H, K, int'(eff_stride)));
                  cnt      <= '0;
                  kx       <= '0;
                  ky       <= '0;
                  ox       <= '0;
                  oy       <= '0;
               end
            end
            LOAD_KERNEL: begin
               cnt <= (cnt == CW'(KK)) ? '0 : cnt + CW'(1);
            end
            MAC: begin
               if (cnt == CW'(KK - 1)) begin
                  cnt <= '0;
                  kx  <= '0;
                  ky  <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (kx == DW'(K - 1)) begin
                     kx <= '0;
                     ky <= ky + DW'(1);
                  end else begin
                     kx <= kx + DW'(1);
                  end
               end
            end
            OUTPUT: begin
               if (i_ready) begin
                  if (ox == ow - DW'(1)) begin
                     ox <= '0;
                     oy <= oy + DW'(1);
                  end else begin
                     ox <= ox + DW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   conv_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk (i_clk),
      .rst (i_rst),
      .en  (mac_en),
      .clr (mac_clr),
      .a   (i_src_data),
      .b   (kernel[rd_idx]),
      .acc (acc)
   );

endmodule
